// File: rtl/jtag_pkg.sv
// Shared constants and helpers for test data registers.
// Holds the default/legal TDR widths and a constant-evaluable ceil(log2) helper
// used to size counters from a register width.
package jtag_pkg;

  localparam int TDR_WIDTH_DEFAULT = 8;
  localparam int TDR_WIDTH_MIN     = 2;
  localparam int TDR_WIDTH_MAX     = 64;

  // Number of bits needed to encode values 0..value-1.
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/bypass_cell.sv
// One-bit bypass flop.
// Ports:
//   clk     - test clock (rising edge)
//   rst     - asynchronous active-high reset, clears the flop
//   tdi     - serial data in
//   capture - load 0
//   shift   - load tdi (capture has priority)
//   q       - flop output
module bypass_cell
  import jtag_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tdi,
  input  logic capture,
  input  logic shift,
  output logic q
);

  logic q_r;

  // Capture forces a known 0, shift samples TDI, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= 1'b0;
    end else if (capture) begin
      q_r <= 1'b0;
    end else if (shift) begin
      q_r <= tdi;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/data_register.sv
// JTAG-style test data register with shift stage, update stage and bypass.
// Ports:
//   TCK          - test clock, all state changes on its rising edge
//   Reset        - asynchronous active-high reset
//   TDI          - serial data in
//   CaptureDR    - parallel load of ParallelIn into the shift stage
//   ShiftDR      - shift TDI in (right shift, TDI enters the MSB)
//   UpdateDR     - commit shift stage to ParallelOut (gated, see below)
//   Bypass       - 1 selects the 1-bit bypass path
//   ParallelIn   - capture data
//   ParallelOut  - update-stage contents
//   TDO          - serial out: shift-stage bit 0 or bypass flop
//   ShiftCount   - shifts since last capture, saturating at WIDTH
//   Overrun      - sticky: shifted while ShiftCount was already WIDTH
//   UpdateDone   - one-cycle pulse after a committed update
module data_register
  import jtag_pkg::*;
#(
  parameter int               WIDTH         = TDR_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter bit               STRICT_UPDATE = 1'b1
) (
  input  logic                        TCK,
  input  logic                        Reset,
  input  logic                        TDI,
  input  logic                        CaptureDR,
  input  logic                        ShiftDR,
  input  logic                        UpdateDR,
  input  logic                        Bypass,
  input  logic [WIDTH-1:0]            ParallelIn,
  output logic [WIDTH-1:0]            ParallelOut,
  output logic                        TDO,
  output logic [clog2(WIDTH+1)-1:0]   ShiftCount,
  output logic                        Overrun,
  output logic                        UpdateDone
);

  localparam int               CNT_W      = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(WIDTH);

  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] parallel_out_r;
  logic [CNT_W-1:0] count_r;
  logic             overrun_r;
  logic             update_done_r;
  logic             bypass_q_s;
  logic             count_full_s;
  logic             commit_s;

  bypass_cell u_bypass (
    .clk     (TCK),
    .rst     (Reset),
    .tdi     (TDI),
    .capture (CaptureDR),
    .shift   (ShiftDR),
    .q       (bypass_q_s)
  );

  assign count_full_s = (count_r == FULL_COUNT);

  // Update gate: in strict mode only a clean, complete scan may be committed.
  // Uses current (pre-shift, pre-increment) state so a simultaneous shift
  // does not affect what gets committed.
  always_comb begin
    commit_s = 1'b0;
    if (UpdateDR && !Bypass) begin
      if (!STRICT_UPDATE) begin
        commit_s = 1'b1;
      end else begin
        commit_s = count_full_s && !overrun_r;
      end
    end else begin
      commit_s = 1'b0;
    end
  end

  // Shift stage, shift counter and overrun flag; all frozen while bypassed.
  always_ff @(posedge TCK or posedge Reset) begin
    if (Reset) begin
      shift_r   <= RESET_VALUE;
      count_r   <= '0;
      overrun_r <= 1'b0;
    end else if (!Bypass) begin
      if (CaptureDR) begin
        shift_r   <= ParallelIn;
        count_r   <= '0;
        overrun_r <= 1'b0;
      end else if (ShiftDR) begin
        shift_r <= {TDI, shift_r[WIDTH-1:1]};
        if (count_full_s) begin
          overrun_r <= 1'b1;
        end else begin
          count_r <= count_r + 1'b1;
        end
      end else begin
        shift_r <= shift_r;
      end
    end else begin
      shift_r <= shift_r;
    end
  end

  // Update stage and its completion pulse.
  always_ff @(posedge TCK or posedge Reset) begin
    if (Reset) begin
      parallel_out_r <= RESET_VALUE;
      update_done_r  <= 1'b0;
    end else if (commit_s) begin
      parallel_out_r <= shift_r;
      update_done_r  <= 1'b1;
    end else begin
      update_done_r  <= 1'b0;
    end
  end

  // TDO is a plain mux of flop outputs so a Bypass change shows immediately.
  assign TDO         = Bypass ? bypass_q_s : shift_r[0];
  assign ParallelOut = parallel_out_r;
  assign ShiftCount  = count_r;
  assign Overrun     = overrun_r;
  assign UpdateDone  = update_done_r;

endmodule

// File: tb/tb_data_register.sv
module tb_data_register;

  localparam int         W    = 8;
  localparam logic [7:0] RSTV = 8'h5A;

  logic       clk = 1'b0;
  logic       rst;
  logic       tdi, cap, sh, upd, byp;
  logic [7:0] pin;
  logic [7:0] pout;
  logic       tdo;
  logic [3:0] scnt;
  logic       ovr;
  logic       done;

  data_register #(.WIDTH(W), .RESET_VALUE(RSTV), .STRICT_UPDATE(1'b1)) dut (
    .TCK(clk), .Reset(rst), .TDI(tdi), .CaptureDR(cap), .ShiftDR(sh),
    .UpdateDR(upd), .Bypass(byp), .ParallelIn(pin), .ParallelOut(pout),
    .TDO(tdo), .ShiftCount(scnt), .Overrun(ovr), .UpdateDone(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tdo;
    int         cnt;
    logic       ovr;
    logic       done;
    logic [7:0] po;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] upd_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  logic [7:0] m_shift;
  logic [7:0] m_po;
  logic       m_byp;
  int         m_cnt;
  logic       m_ovr;
  logic       m_done;

  function automatic void chk(input string name, input longint act, input longint expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endfunction

  // Monitor: at each falling edge compare observed outputs against the oldest
  // expectation; on an UpdateDone pulse compare the committed word.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("tdo", tdo, e.tdo);
      chk("shift_count", scnt, e.cnt);
      chk("overrun", ovr, e.ovr);
      chk("update_done", done, e.done);
      chk("parallel_out", pout, e.po);
      if (done === 1'b1) begin
        if (upd_q.size() > 0) chk("committed_word", pout, upd_q.pop_front());
        else chk("unexpected_update", 1, 0);
      end
    end
  end

  task automatic model_reset();
    m_shift = RSTV; m_po = RSTV; m_byp = 1'b0;
    m_cnt = 0; m_ovr = 1'b0; m_done = 1'b0;
  endtask

  // One TCK cycle: called at posedge+1, drives inputs, records what the
  // monitor must see at the coming falling edge, then advances the model.
  task automatic step(input logic r, input logic c, input logic s, input logic u,
                      input logic b, input logic t, input logic [7:0] p);
    exp_t e;
    bit   commit;
    rst = r; cap = c; sh = s; upd = u; byp = b; tdi = t; pin = p;
    if (r) model_reset();
    e.tdo = b ? m_byp : m_shift[0];
    e.cnt = m_cnt; e.ovr = m_ovr; e.done = m_done; e.po = m_po;
    exp_q.push_back(e);
    if (!r) begin
      commit = u && !b && (m_cnt == W) && !m_ovr;
      m_done = commit;
      if (commit) begin
        m_po = m_shift;
        upd_q.push_back(m_shift);
      end
      if (c) m_byp = 1'b0;
      else if (s) m_byp = t;
      if (!b) begin
        if (c) begin
          m_shift = p; m_cnt = 0; m_ovr = 1'b0;
        end else if (s) begin
          if (m_cnt == W) m_ovr = 1'b1;
          m_cnt = (m_cnt + 1 > W) ? W : m_cnt + 1;
          m_shift = (m_shift >> 1) | (8'(t) << 7);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic b);
    step(1'b0, 1'b0, 1'b0, 1'b0, b, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] v;
    rst = 1'b1; cap = 1'b0; sh = 1'b0; upd = 1'b0; byp = 1'b0; tdi = 1'b0; pin = 8'h00;
    model_reset();
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
    idle(1'b0);

    // Capture A5, shift in 3C LSB first, update
    v = 8'h3C;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, v[i], 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(1'b0); idle(1'b0);

    // Short shift: update must be refused
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, i[0], 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(1'b0);

    // Overrun: 9 shifts, update ignored, capture clears
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81);
    idle(1'b0);

    // Bypass path: capture then 1,1,0; toggle Bypass back
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hEE);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    idle(1'b1); idle(1'b0); idle(1'b1); idle(1'b0);

    // Simultaneous shift and update at full count
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h96);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'($urandom_range(1)), 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
    idle(1'b0); idle(1'b0);

    // Reset mid-shift, then an update that must be ignored
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(199) == 0),
           ($urandom_range(11) == 0),
           ($urandom_range(3) != 0),
           ($urandom_range(5) == 0),
           ($urandom_range(7) == 0),
           1'($urandom_range(1)),
           8'($urandom));
    end
    idle(1'b0); idle(1'b0);

    chk("exp_queue_drained", exp_q.size(), 0);
    chk("update_queue_drained", upd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
